// File: rtl/priority_encoder_8_3_seq.sv
// priority_encoder_8_3_seq
// Sequential 8-to-3 priority encoder with valid/ready handshakes on both sides.
// One request vector is captured per input handshake. The block then emits one
// output beat per asserted bit, in priority order, carrying that bit's index.
// An empty vector produces a single beat with out_gs=0.
// The ACT_LOW parameter selects the input polarity. With ACT_LOW=1, a 0 bit is a
// request, matching the active-low decoder outputs.
// Optional build macro PRIORITY_ENCODER_LSB_FIRST_EN: when defined, index 0 is
// emitted first instead of index 7.
// All outputs come straight from flops. Their next values are derived from the
// next-state pending mask, so there is no combinational path from any input to
// any output.

module priority_encoder_8_3_seq #(
  parameter bit ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_req,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic       out_gs,
  output logic       out_last
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [2:0] out_code_q, out_code_d;
  logic       out_gs_q, out_gs_d;
  logic       out_last_q, out_last_d;

  // Index of the highest set bit (0 when the vector is empty).
  function automatic logic [2:0] msb_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [2:0] lsb_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // True when at most one bit is set. The empty vector also counts as final.
  function automatic logic at_most_one(input logic [7:0] v);
    return ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Selects the bit that is emitted next, according to the build's order.
  function automatic logic [2:0] pick_index(input logic [7:0] v);
`ifdef PRIORITY_ENCODER_LSB_FIRST_EN
    return lsb_index(v);
`else
    return msb_index(v);
`endif
  endfunction

  // Next-state logic, plus the next output values decoded from next state.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    in_ready_d  = 1'b1;
    out_valid_d = 1'b0;
    out_code_d  = 3'd0;
    out_gs_d    = 1'b0;
    out_last_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pend_d  = ACT_LOW ? ~in_req : in_req;
          state_d = S_EMIT;
        end else begin
          pend_d  = 8'd0;
          state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (out_last_q) begin
            pend_d  = 8'd0;
            state_d = S_IDLE;
          end else begin
            // Drop the bit that just transferred; the next one becomes current.
            pend_d  = pend_q & ~(8'd1 << out_code_q);
            state_d = S_EMIT;
          end
        end else begin
          pend_d  = pend_q;
          state_d = S_EMIT;
        end
      end
      default: begin
        pend_d  = 8'd0;
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_EMIT) begin
      in_ready_d  = 1'b0;
      out_valid_d = 1'b1;
      out_code_d  = pick_index(pend_d);
      out_gs_d    = |pend_d;
      out_last_d  = at_most_one(pend_d);
    end else begin
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      out_code_d  = 3'd0;
      out_gs_d    = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // State and pending-mask registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Registered handshake and beat outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_code_q  <= 3'd0;
      out_gs_q    <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_gs_q    <= out_gs_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_gs    = out_gs_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_priority_encoder_8_3_seq.sv
// Bench for priority_encoder_8_3_seq (ACT_LOW=1).
// Expected beats are pushed onto a queue when a vector is driven. A monitor pops
// and compares them on every output transfer.

module tb_priority_encoder_8_3_seq;

  localparam bit ACT_LOW = 1'b1;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_req;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_gs;
  logic       out_last;

  int total = 0;
  int bad   = 0;
  logic [4:0] exp_q[$];   // {code, gs, last}
  bit   bp_en = 1'b0;

  typedef struct {
    logic [7:0]  req;
    int          n;       // number of beats
    logic [31:0] codes;   // MSB-first beat order, first beat in the top nibble
    logic        gs;
  } vec_t;

  vec_t tbl[7];

  priority_encoder_8_3_seq #(.ACT_LOW(ACT_LOW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_req   (in_req),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_code (out_code),
    .out_gs   (out_gs),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Push the beats listed in a table entry, reordered for LSB-first builds.
  task automatic push_tbl(input vec_t v);
    logic [31:0] t;
    int idx;
    for (int j = 0; j < v.n; j++) begin
`ifdef PRIORITY_ENCODER_LSB_FIRST_EN
      idx = v.n - 1 - j;
`else
      idx = j;
`endif
      t = v.codes >> (28 - 4 * idx);
      exp_q.push_back({t[2:0], v.gs, (j == v.n - 1) ? 1'b1 : 1'b0});
    end
  endtask

  // Reference model for random vectors: walk the bits in priority order.
  task automatic push_model(input logic [7:0] req);
    logic [7:0] p;
    int cnt;
    int k;
    p   = ACT_LOW ? ~req : req;
    cnt = $countones(p);
    k   = 0;
    if (cnt == 0) begin
      exp_q.push_back({3'd0, 1'b0, 1'b1});
    end else begin
      for (int s = 0; s < 8; s++) begin
`ifdef PRIORITY_ENCODER_LSB_FIRST_EN
        int b = s;
`else
        int b = 7 - s;
`endif
        if (p[b]) begin
          k++;
          exp_q.push_back({3'(b), 1'b1, (k == cnt) ? 1'b1 : 1'b0});
        end
      end
    end
  endtask

  // Drive one vector once in_ready is seen, then check the one-cycle latency.
  task automatic send(input logic [7:0] req);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1;
      in_req   = req;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_req   = 8'($urandom);
      chk("first_beat_latency", 32'(out_valid), 32'd1);
      chk("in_ready_low_in_emit", 32'(in_ready), 32'd0);
    end
  endtask

  // Wait for all expected beats, then check the block has returned to idle.
  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Monitor: compare each transferred beat with the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("in_ready_while_valid", 32'(in_ready), 32'd0);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {27'd0, out_code, out_gs, out_last}, 32'h1f);
        end else begin
          chk("beat", {27'd0, out_code, out_gs, out_last}, {27'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Random backpressure for the stress phase.
  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    tbl[0] = '{8'hFE, 1, 32'h0000_0000, 1'b1};
    tbl[1] = '{8'h5B, 3, 32'h7520_0000, 1'b1};
    tbl[2] = '{8'hFF, 1, 32'h0000_0000, 1'b0};
    tbl[3] = '{8'h7F, 1, 32'h7000_0000, 1'b1};
    tbl[4] = '{8'hAA, 4, 32'h6420_0000, 1'b1};
    tbl[5] = '{8'h00, 8, 32'h7654_3210, 1'b1};
    tbl[6] = '{8'hEF, 1, 32'h4000_0000, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_req    = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_code", 32'(out_code), 32'd0);
    chk("rst_out_gs", 32'(out_gs), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);

    // Table-driven vectors with out_ready held high.
    for (int i = 0; i < 7; i++) begin
      push_tbl(tbl[i]);
      send(tbl[i].req);
      drain();
    end

    // Stall: out_code must hold at 7 for 4 cycles, then emit 7 and 6 (last).
    out_ready = 1'b0;
`ifdef PRIORITY_ENCODER_LSB_FIRST_EN
    exp_q.push_back({3'd0, 1'b1, 1'b0});
    exp_q.push_back({3'd1, 1'b1, 1'b0});
    exp_q.push_back({3'd2, 1'b1, 1'b0});
    exp_q.push_back({3'd3, 1'b1, 1'b0});
    exp_q.push_back({3'd4, 1'b1, 1'b0});
    exp_q.push_back({3'd5, 1'b1, 1'b1});
    send(8'b1100_0000);
    for (int c = 0; c < 4; c++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_code", 32'(out_code), 32'd0);
      @(posedge clk);
      #1;
    end
`else
    exp_q.push_back({3'd7, 1'b1, 1'b0});
    exp_q.push_back({3'd6, 1'b1, 1'b1});
    send(8'b0011_1111);
    for (int c = 0; c < 4; c++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_code", 32'(out_code), 32'd7);
      chk("stall_last", 32'(out_last), 32'd0);
      @(posedge clk);
      #1;
    end
`endif
    out_ready = 1'b1;
    drain();

    // Reset after the first beat of an all-asserted vector.
    exp_q.push_back(
`ifdef PRIORITY_ENCODER_LSB_FIRST_EN
      {3'd0, 1'b1, 1'b0}
`else
      {3'd7, 1'b1, 1'b0}
`endif
    );
    send(8'b0000_0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("first_beat_consumed", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_outs", {29'd0, out_code, out_gs, out_last} >> 0, 32'd0);
    exp_q.push_back({3'd4, 1'b1, 1'b1});
    send(8'b1110_1111);
    drain();

    // Random vectors with random backpressure.
    bp_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if (r % 5 == 0) v = 8'hFF;
      push_model(v);
      send(v);
    end
    bp_en = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
